// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared types, constants and helpers for the fetch stage
//
// Purpose : common definitions for the instruction-fetch front end.
// Contents: IF_XLEN      - PC / instruction width carried by a fetch slot
//           PC_STEP      - sequential fetch increment (one 32-bit word)
//           fetch_slot_t - one prefetch slot {pc, inst, filled}
//           align_pc()   - clears the byte-offset bits of a fetch address
package if_stage_pkg;

   localparam int unsigned IF_XLEN = 32;

   localparam logic [IF_XLEN-1:0] PC_STEP = IF_XLEN'(4);

   typedef struct packed {
      logic [IF_XLEN-1:0] pc;
      logic [IF_XLEN-1:0] inst;
      logic               filled;
   } fetch_slot_t;

   // Instruction fetch is always word aligned; low two address bits are dropped.
   function automatic logic [IF_XLEN-1:0] align_pc(input logic [IF_XLEN-1:0] pc);
      return {pc[IF_XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_prefetch_buf.sv
// rtl/if_prefetch_buf.sv - slot-reserving prefetch buffer for in-order fetch responses
//
// Purpose : a slot is reserved (pc known, inst unknown) when a fetch request is
//           accepted, filled in request order as responses arrive, and popped
//           from the head once filled.
// Ports   : i_clk       core clock
//           i_rst       synchronous active-high reset, clears every slot
//           i_flush     invalidate all slots and rewind pointers
//           i_push      reserve tail slot with i_push_pc
//           i_push_pc   PC of the request being reserved
//           i_fill      write i_fill_inst into the oldest unfilled slot
//           i_fill_inst instruction word for the fill
//           i_pop       retire head slot (only legal while head is filled)
//           o_head      current head slot contents
//           o_count     reserved slots (filled or not)
//           o_pending   reserved slots still waiting for a response
module if_prefetch_buf
   import if_stage_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = PW + 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic [IF_XLEN-1:0] i_push_pc,
   input  logic               i_fill,
   input  logic [IF_XLEN-1:0] i_fill_inst,
   input  logic               i_pop,
   output fetch_slot_t        o_head,
   output logic [CW-1:0]      o_count,
   output logic [CW-1:0]      o_pending
);

   fetch_slot_t   r_slot [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [PW-1:0] r_fill;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_pending;

   // Push, fill and pop always address distinct slots: the tail is unreserved
   // whenever a push is allowed, the fill slot is reserved-but-empty, and the
   // head is only popped once it is filled.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_slot[i] <= '0;
         end
         r_head    <= '0;
         r_tail    <= '0;
         r_fill    <= '0;
         r_count   <= '0;
         r_pending <= '0;
      end else if (i_flush) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_slot[i].filled <= 1'b0;
         end
         r_head    <= '0;
         r_tail    <= '0;
         r_fill    <= '0;
         r_count   <= '0;
         r_pending <= '0;
      end else begin
         if (i_push) begin
            r_slot[r_tail].pc     <= i_push_pc;
            r_slot[r_tail].filled <= 1'b0;
            r_tail                <= r_tail + 1'b1;
         end
         if (i_fill) begin
            r_slot[r_fill].inst   <= i_fill_inst;
            r_slot[r_fill].filled <= 1'b1;
            r_fill                <= r_fill + 1'b1;
         end
         if (i_pop) begin
            r_slot[r_head].filled <= 1'b0;
            r_head                <= r_head + 1'b1;
         end
         r_count   <= r_count + CW'(i_push) - CW'(i_pop);
         r_pending <= r_pending + CW'(i_push) - CW'(i_fill);
      end
   end

   assign o_head    = r_slot[r_head];
   assign o_count   = r_count;
   assign o_pending = r_pending;

endmodule

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - variable-latency instruction prefetch front end
//
// Purpose : issues in-order word fetches, parks in-flight PCs in a prefetch
//           buffer, hands {pc, inst} to decode with valid/ready, and restarts
//           on redirect while silently dropping responses to stale requests.
// Ports   : clk            core clock
//           rst            synchronous active-high reset
//           imem_req_valid fetch request valid
//           imem_req_ready memory accepts request
//           imem_req_addr  word-aligned fetch address
//           imem_rsp_valid response valid (responses return in request order)
//           imem_rsp_data  instruction word
//           redirect_valid flush and restart fetch
//           redirect_pc    restart address (bits [1:0] ignored)
//           if_valid       head instruction available
//           if_ready       decode accepts head instruction
//           if_pc          PC of head instruction
//           if_inst        head instruction
module if_prefetch_unit
   import if_stage_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = IF_XLEN,
   parameter int unsigned           BUF_DEPTH  = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_inst
);

   localparam int unsigned   CW      = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

   logic [DATA_WIDTH-1:0] r_fetch_pc;
   // Responses still owed by memory for requests made before a redirect.
   logic [CW-1:0]         r_drop_cnt;

   fetch_slot_t           w_head;
   logic [CW-1:0]         w_count;
   logic [CW-1:0]         w_pending;
   logic [CW:0]           w_occupancy;
   logic                  w_room;
   logic                  w_req_fire;
   logic                  w_rsp_drop;
   logic                  w_fill;
   logic                  w_pop;

   // Outstanding requests are bounded by stale + reserved slots, so every
   // response that can ever arrive already owns either a drop credit or a slot.
   assign w_occupancy = {1'b0, r_drop_cnt} + {1'b0, w_count};
   assign w_room      = (w_count < DEPTH_C) && (w_occupancy < {1'b0, DEPTH_C});

   assign imem_req_valid = !rst && !redirect_valid && w_room;
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != '0);
   assign w_fill     = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
   assign w_pop      = w_head.filled && if_ready && !redirect_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_drop_cnt <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= align_pc(redirect_pc);
         // Every still-empty slot becomes a stale response; a response landing
         // this very cycle is discarded now, so it no longer needs a credit.
         r_drop_cnt <= r_drop_cnt + w_pending - CW'(imem_rsp_valid);
      end else begin
         if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
         end
         r_drop_cnt <= r_drop_cnt - CW'(w_rsp_drop);
      end
   end

   if_prefetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_flush     (redirect_valid),
      .i_push      (w_req_fire),
      .i_push_pc   (r_fetch_pc),
      .i_fill      (w_fill),
      .i_fill_inst (imem_rsp_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_pending   (w_pending)
   );

   // Decode sees registered slot storage only.
   assign if_valid = w_head.filled;
   assign if_pc    = w_head.pc;
   assign if_inst  = w_head.inst;

   a_rsp_owned: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> ((r_drop_cnt != '0) || (w_pending != '0)));

   a_drop_bound: assert property (@(posedge clk) disable iff (rst)
      w_occupancy <= {1'b0, DEPTH_C});

endmodule
